im_loader: RTL and testbench
============================

# im_loader

Parametrised instruction memory with a self-clearing reset sweep, a streaming byte loader with valid/ready handshake and auto-incrementing write pointer, and a registered multi-byte fetch port. It sits between the program-load path (host/UART byte stream) and the CPU fetch stage. It replaces the fixed 256×8, 16-bit-fetch instruction store.

## Interface
- ADDR_W, 8, byte address width; DEPTH = 2**ADDR_W bytes
- INST_BYTES, 2, bytes per fetched instruction (≥1)
- FILL, 8'hFF, byte value written by the clear sweep and returned when fetch is blocked

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- load_start  in  1  one-cycle request to begin a load session (honoured in IDLE only)
- load_base  in  ADDR_W  first write address, sampled with load_start
- load_end  in  1  terminates the load session (honoured in LOAD only)
- ld_valid  in  1  ld_data valid
- ld_data  in  8  byte to store
- ld_ready  out  1  loader accepts a byte this cycle
- busy  out  1  state ≠ IDLE
- loaded_cnt  out  ADDR_W+1  bytes accepted in the current/last session
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  address of first (most significant) byte
- fetch_valid  out  1  fetch_inst valid
- fetch_inst  out  8*INST_BYTES  fetched instruction

## Operation
- States: CLEAR, IDLE, LOAD.
- Reset (rst=0): state=CLEAR, clr_ptr=0, wr_ptr=0, loaded_cnt=0, ld_ready=0, fetch_valid=0, fetch_inst={INST_BYTES{FILL}}; busy=1 (CLEAR). Memory contents not touched by reset itself.
- CLEAR: each cycle mem[clr_ptr]←FILL, clr_ptr++. After writing address DEPTH-1 → IDLE (exactly DEPTH cycles after rst release).
- IDLE: load_start=1 → LOAD; wr_ptr←load_base, loaded_cnt←0. load_end ignored.
- LOAD: ld_ready=1 while loaded_cnt<DEPTH. Accept = ld_valid&ld_ready: mem[wr_ptr]←ld_data, wr_ptr←(wr_ptr+1) mod DEPTH, loaded_cnt++.
  - Accept that makes loaded_cnt=DEPTH → IDLE (full); ld_ready=0 thereafter.
  - load_end=1 → IDLE; a byte accepted in the same cycle is written and counted first.
  - load_start in LOAD or CLEAR ignored.
- ld_ready=0 in CLEAR and IDLE; ld_ready is a registered function of state only (no combinational path from ld_valid).
- loaded_cnt holds its value in IDLE until next load_start.
- Fetch: byte k of fetch_inst (k=0 MSB) = mem[(fetch_addr+k) mod DEPTH]; big-endian, wraps at DEPTH-1→0.
- Fetch while busy=1: fetch_valid still pulses, fetch_inst={INST_BYTES{FILL}} (CPU sees all-ones no-op pattern; no read of partially loaded memory).
- Write pointer wrap-around is legal: a load starting near DEPTH-1 continues at 0.

## Timing
- Fetch latency 1: fetch_req at edge N → fetch_valid=1, fetch_inst updated after edge N+1; fetch_valid=0 the cycle after a cycle without fetch_req; fetch_inst holds last value.
- Fetch in the cycle a byte is written to the same address returns the old byte (read-before-write); busy decides FILL substitution using state at the sampling edge.
- load_start → ld_ready=1 the next cycle; first byte can be accepted then.
- load_end / full → ld_ready=0 the next cycle; busy=0 the next cycle.
- Back-to-back: one byte per cycle sustained.
- rst asserted mid-LOAD: immediate return to CLEAR, partially loaded image is wiped by the sweep; outputs take reset values asynchronously.
- Throughput of clear: DEPTH cycles; no early exit.

## Test plan
- Reset release, ADDR_W=8: busy=1 for 256 cycles, then 0; fetch 0x00 after → 16'hFFFF, fetch_valid 1 cycle after req.
- load_start base=0x10, bytes 0x12,0x34,0x56 with ld_valid gaps, load_end with last byte → loaded_cnt=3; fetch 0x10 → 16'h1234, fetch 0x11 → 16'h3456.
- Wrap: base=0xFF, bytes 0xAB,0xCD, load_end → mem[0xFF]=0xAB, mem[0x00]=0xCD; fetch 0xFF → 16'hABCD.
- Fetch during LOAD at loaded address → 16'hFFFF; after load_end same fetch → stored data.
- Full: 256 back-to-back bytes with no load_end → loaded_cnt=256, ld_ready drops after 256th accept, busy=0 next cycle.
- rst pulsed after 5 accepted bytes → CLEAR restarts, after 256 cycles fetch of loaded address → 16'hFFFF; INST_BYTES=4 variant fetch 0xFE → {mem[FE],mem[FF],mem[00],mem[01]}.

Source files
------------

// File: rtl/im_loader.sv
// im_loader
//
// Byte-addressed instruction memory that sits between the program-load byte
// stream (host/UART) and the CPU fetch stage.
//
//   * After reset the whole array is swept to FILL, one byte per cycle, so a
//     reset always leaves a known all-FILL image, whatever was loaded before.
//   * A load session starts with load_start (carrying load_base). Bytes are
//     then accepted on ld_valid & ld_ready. Each byte is written at an
//     auto-incrementing pointer that wraps modulo DEPTH. The session ends on
//     load_end or once DEPTH bytes have been accepted.
//   * The fetch port returns INST_BYTES consecutive bytes, big-endian, one
//     cycle after fetch_req. While the block is busy (clearing or loading),
//     the port returns the FILL pattern instead of memory contents.
//
// Parameters
//   ADDR_W      byte address width, DEPTH = 2**ADDR_W
//   INST_BYTES  bytes per fetched instruction (>= 1)
//   FILL        byte written by the clear sweep and returned while busy
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous, active-low reset
//   load_start  begin a load session (only honoured in IDLE)
//   load_base   first write address, sampled with load_start
//   load_end    end the load session (only honoured in LOAD)
//   ld_valid    ld_data carries a byte
//   ld_data     byte to store
//   ld_ready    loader accepts a byte this cycle
//   busy        block is clearing or loading
//   loaded_cnt  bytes accepted in the current/last session
//   fetch_req   fetch request
//   fetch_addr  address of the first (most significant) fetched byte
//   fetch_valid fetch_inst holds a fresh result
//   fetch_inst  fetched instruction
module im_loader #(
    parameter int          ADDR_W     = 8,
    parameter int          INST_BYTES = 2,
    parameter logic [7:0]  FILL       = 8'hFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic [ADDR_W-1:0]       load_base,
    input  logic                    load_end,
    input  logic                    ld_valid,
    input  logic [7:0]              ld_data,
    output logic                    ld_ready,
    output logic                    busy,
    output logic [ADDR_W:0]         loaded_cnt,
    input  logic                    fetch_req,
    input  logic [ADDR_W-1:0]       fetch_addr,
    output logic                    fetch_valid,
    output logic [8*INST_BYTES-1:0] fetch_inst
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    // Count value just before the array is full.
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        LOAD
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [7:0]              mem [DEPTH];

    logic [ADDR_W-1:0]       clr_ptr;
    logic [ADDR_W-1:0]       wr_ptr;
    logic                    accept;

    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_waddr;
    logic [7:0]              mem_wdata;

    logic [ADDR_W-1:0]       rd_addr;
    logic [8*INST_BYTES-1:0] fetch_word;

    // ld_ready depends only on the state register, so a byte is accepted
    // without any combinational path from ld_valid back to ld_ready.
    assign accept = ld_valid & ld_ready;

    // State register. Reset always restarts the clear sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The sweep cannot exit early: it leaves CLEAR only
    // after writing the last address. A load ends on load_end, or when an
    // accepted byte fills all DEPTH locations.
    always_comb begin
        state_next = state;
        case (state)
            CLEAR: begin
                if (&clr_ptr) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (load_end || (accept && (loaded_cnt == CNT_LAST))) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Output and write-port decode. The memory has one write port: the
    // sweep owns it during CLEAR, and the byte stream owns it during LOAD.
    always_comb begin
        busy      = 1'b1;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = FILL;
        case (state)
            CLEAR: begin
                mem_we = 1'b1;
            end
            IDLE: begin
                busy = 1'b0;
            end
            LOAD: begin
                ld_ready  = 1'b1;
                mem_we    = ld_valid;
                mem_waddr = wr_ptr;
                mem_wdata = ld_data;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Sweep and load pointers. loaded_cnt keeps its final value through
    // IDLE, so software can read back how much was loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_ptr    <= '0;
            wr_ptr     <= '0;
            loaded_cnt <= '0;
        end else begin
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + ADDR_W'(1);
            end
            if ((state == IDLE) && load_start) begin
                wr_ptr     <= load_base;
                loaded_cnt <= '0;
            end else if (accept) begin
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                loaded_cnt <= loaded_cnt + (ADDR_W + 1)'(1);
            end
        end
    end

    // Storage array. It is deliberately left out of reset: the clear sweep
    // provides the known contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Gather INST_BYTES bytes big-endian. The address wraps naturally
    // through the ADDR_W-bit add.
    always_comb begin
        fetch_word = '0;
        rd_addr    = fetch_addr;
        for (int k = 0; k < INST_BYTES; k++) begin
            rd_addr = fetch_addr + ADDR_W'(k);
            fetch_word[8*(INST_BYTES-1-k) +: 8] = mem[rd_addr];
        end
    end

    // Registered fetch port. The array is read before the same edge's write
    // lands, so a same-cycle write returns the old byte. The FILL
    // substitution uses the state at the sampling edge. fetch_inst holds its
    // value between requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_valid <= 1'b0;
            fetch_inst  <= {INST_BYTES{FILL}};
        end else begin
            fetch_valid <= fetch_req;
            if (fetch_req) begin
                fetch_inst <= busy ? {INST_BYTES{FILL}} : fetch_word;
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Testbench for im_loader.
//
// Two instances share every load-path input:
//   * a 16-bit fetch instance (INST_BYTES=2);
//   * a 32-bit fetch instance (INST_BYTES=4) with its own fetch_req.
// Stimulus pushes the hand-computed expected fetch word into a queue.
// Independent negedge monitors pop and compare whenever an instance raises
// fetch_valid. Direct status checks are taken #1 after the rising edge.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  load_base;
    logic        load_end;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        fetch_req;
    logic        fetch_req4;
    logic [7:0]  fetch_addr;

    logic        ld_ready;
    logic        busy;
    logic [8:0]  loaded_cnt;
    logic        fetch_valid;
    logic [15:0] fetch_inst;

    logic        ld_ready4;
    logic        busy4;
    logic [8:0]  loaded_cnt4;
    logic        fetch_valid4;
    logic [31:0] fetch_inst4;

    int          vectors     = 0;
    int          miscompares = 0;

    logic [15:0] q2[$];
    logic [31:0] q4[$];

    always #5 clk = ~clk;

    im_loader #(.ADDR_W(8), .INST_BYTES(2), .FILL(8'hFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_end    (load_end),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .busy        (busy),
        .loaded_cnt  (loaded_cnt),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst)
    );

    im_loader #(.ADDR_W(8), .INST_BYTES(4), .FILL(8'hFF)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_end    (load_end),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready4),
        .busy        (busy4),
        .loaded_cnt  (loaded_cnt4),
        .fetch_req   (fetch_req4),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid4),
        .fetch_inst  (fetch_inst4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One clock of loader inputs, then all one-shot requests drop.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e);
        ld_valid = v;
        ld_data  = d;
        load_end = e;
        tick();
        ld_valid   = 1'b0;
        load_end   = 1'b0;
        load_start = 1'b0;
        fetch_req  = 1'b0;
        fetch_req4 = 1'b0;
    endtask

    task automatic issueFetch(input logic [7:0] addr, input logic [15:0] exp_word);
        fetch_addr = addr;
        fetch_req  = 1'b1;
        q2.push_back(exp_word);
    endtask

    task automatic issueFetch4(input logic [7:0] addr, input logic [31:0] exp_word);
        fetch_addr = addr;
        fetch_req4 = 1'b1;
        q4.push_back(exp_word);
    endtask

    task automatic doFetch(input logic [7:0] addr, input logic [15:0] exp_word);
        issueFetch(addr, exp_word);
        applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic startLoad(input logic [7:0] base);
        load_base  = base;
        load_start = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    // The sweep takes exactly 256 edges after reset release.
    task automatic waitClear(input string tag);
        repeat (255) tick();
        checkOutput({tag, "_busy_at_255"}, 32'(busy), 32'd1);
        tick();
        checkOutput({tag, "_busy_at_256"}, 32'(busy), 32'd0);
    endtask

    // Scoreboard monitors: pop one expectation per presented fetch.
    always @(negedge clk) begin
        if (fetch_valid) begin
            if (q2.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL fetch2_unexpected: got %0h, expected no fetch", fetch_inst);
            end else begin
                checkOutput("fetch2", 32'(fetch_inst), 32'(q2.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (fetch_valid4) begin
            if (q4.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL fetch4_unexpected: got %0h, expected no fetch", fetch_inst4);
            end else begin
                checkOutput("fetch4", fetch_inst4, q4.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b0;
        load_start = 1'b0;
        load_base  = 8'h00;
        load_end   = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = 8'h00;
        fetch_req  = 1'b0;
        fetch_req4 = 1'b0;
        fetch_addr = 8'h00;

        // Reset state
        repeat (3) tick();
        checkOutput("rst_busy",        32'(busy),        32'd1);
        checkOutput("rst_ld_ready",    32'(ld_ready),    32'd0);
        checkOutput("rst_loaded_cnt",  32'(loaded_cnt),  32'd0);
        checkOutput("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        checkOutput("rst_fetch_inst",  32'(fetch_inst),  32'h0000FFFF);
        checkOutput("rst_fetch_inst4", fetch_inst4,      32'hFFFFFFFF);
        rst = 1'b1;
        waitClear("clr1");

        // Blank memory after the sweep, with latency-1 valid
        doFetch(8'h00, 16'hFFFF);
        checkOutput("fetch_valid_lat1", 32'(fetch_valid), 32'd1);
        tick();
        checkOutput("fetch_valid_drop", 32'(fetch_valid), 32'd0);

        // Load at 0x10 with gaps; probe the loaded address while busy
        startLoad(8'h10);
        checkOutput("load_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("load_busy",     32'(busy),     32'd1);
        applyStimulus(1'b1, 8'h12, 1'b0);
        issueFetch(8'h10, 16'hFFFF);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h34, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h56, 1'b1);
        checkOutput("load_end_cnt",      32'(loaded_cnt), 32'd3);
        checkOutput("load_end_busy",     32'(busy),       32'd0);
        checkOutput("load_end_ld_ready", 32'(ld_ready),   32'd0);
        doFetch(8'h10, 16'h1234);
        doFetch(8'h11, 16'h3456);

        // Write-pointer wrap-around
        startLoad(8'hFF);
        applyStimulus(1'b1, 8'hAB, 1'b0);
        applyStimulus(1'b1, 8'hCD, 1'b1);
        checkOutput("wrap_cnt", 32'(loaded_cnt), 32'd2);
        doFetch(8'hFF, 16'hABCD);
        doFetch(8'h00, 16'hCDFF);

        // Full: 256 back-to-back bytes, data = i ^ 0x5A. A load_start in
        // mid-session must be ignored.
        startLoad(8'h00);
        for (int i = 0; i < 256; i++) begin
            checkOutput("full_ld_ready", 32'(ld_ready), 32'd1);
            if (i == 100) begin
                load_start = 1'b1;
                load_base  = 8'h80;
            end
            applyStimulus(1'b1, 8'(i) ^ 8'h5A, 1'b0);
        end
        checkOutput("full_cnt",      32'(loaded_cnt), 32'd256);
        checkOutput("full_ld_ready", 32'(ld_ready),   32'd0);
        checkOutput("full_busy",     32'(busy),       32'd0);
        doFetch(8'h00, 16'h5A5B);
        doFetch(8'h10, 16'h4A4B);
        doFetch(8'hFF, 16'hA55A);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("idle_load_end_busy", 32'(busy),       32'd0);
        checkOutput("idle_cnt_hold",      32'(loaded_cnt), 32'd256);

        // Reset in mid-load wipes the partial image
        startLoad(8'h20);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
        end
        checkOutput("pre_rst_cnt", 32'(loaded_cnt), 32'd5);
        rst = 1'b0;
        #1;
        checkOutput("async_rst_busy",     32'(busy),     32'd1);
        checkOutput("async_rst_ld_ready", 32'(ld_ready), 32'd0);
        checkOutput("async_rst_cnt",      32'(loaded_cnt), 32'd0);
        tick();
        rst = 1'b1;
        waitClear("clr2");
        doFetch(8'h20, 16'hFFFF);
        doFetch(8'h00, 16'hFFFF);

        // Load across the wrap, then check the 4-byte fetch variant
        startLoad(8'hFE);
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b1);
        checkOutput("wide_cnt",      32'(loaded_cnt4), 32'd4);
        checkOutput("wide_busy",     32'(busy4),       32'd0);
        checkOutput("wide_ld_ready", 32'(ld_ready4),   32'd0);
        issueFetch4(8'hFE, 32'h11223344);
        applyStimulus(1'b0, 8'h00, 1'b0);
        issueFetch4(8'h00, 32'h3344FFFF);
        applyStimulus(1'b0, 8'h00, 1'b0);
        doFetch(8'hFF, 16'h2233);

        repeat (3) tick();
        checkOutput("q2_drained", 32'(q2.size()), 32'd0);
        checkOutput("q4_drained", 32'(q4.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
